// File: rtl/regfile_write_port.sv
// regfile_write_port: write side of the 32-entry register file with a pending-write stage and a bulk-clear engine
module regfile_write_port #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [4:0]                     wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic                           clear_req,
  output logic                           busy,
  output logic                           clear_done,
  output logic                           pend_valid,
  output logic [4:0]                     pend_addr,
  output logic [DATA_WIDTH-1:0]          pend_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state, state_nx;
  logic [4:0] idx, idx_nx;
  logic accept;
  // clear sequencing: IDLE -> CLEAR sweeps regs 0..NUM_REGS-2 -> DONE pulse -> IDLE
  always_comb begin
    state_nx = (state == IDLE) ? (clear_req ? CLEAR : IDLE) :
               (state == CLEAR) ? ((idx == 5'(NUM_REGS-2)) ? DONE : CLEAR) : IDLE;
    idx_nx = (state == CLEAR) ? idx + 5'd1 : '0;
    wr_ready = (state == IDLE) && !clear_req;
    busy = (state != IDLE);
    clear_done = (state == DONE);
    accept = wr_valid && wr_ready;
  end
  // state and sweep index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
    end
  end
  // capture stage: accepted writes to the zero register are swallowed here
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else begin
      pend_valid <= accept && (wr_addr != 5'(ZERO_REG));
      if (accept && (wr_addr != 5'(ZERO_REG))) begin
        pend_addr <= wr_addr;
        pend_data <= wr_data;
      end
    end
  end
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    if (k == ZERO_REG) begin : g_zero
      assign regs_out[k*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r;
      // commit stage: one-hot decode of the pending address, clear sweep takes priority
      always_ff @(posedge clk) begin
        if (reset || (state == CLEAR && idx == 5'(k))) r <= '0;
        else if (pend_valid && pend_addr == 5'(k)) r <= pend_data;
      end
      assign regs_out[k*DATA_WIDTH +: DATA_WIDTH] = r;
    end
  end
endmodule

// File: tb/tb_regfile_write_port.sv
// tb_regfile_write_port: randomized bench against a behavioural register-file model
module tb_regfile_write_port;
  logic clk = 1'b0;
  logic reset, wr_valid, wr_ready, clear_req, busy, clear_done, pend_valid;
  logic [4:0] wr_addr, pend_addr;
  logic [31:0] wr_data, pend_data;
  logic [1023:0] regs_out;
  int checks = 0;
  int failures = 0;
  logic [31:0] m [32];
  int busy_left;
  bit pv;
  logic [4:0] pa;
  logic [31:0] pd;
  int busy_cnt, done_cnt;

  regfile_write_port dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req), .busy(busy),
    .clear_done(clear_done), .pend_valid(pend_valid), .pend_addr(pend_addr),
    .pend_data(pend_data), .regs_out(regs_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m[k] = '0;
    busy_left = 0;
    pv = 0;
    pa = '0;
    pd = '0;
  endtask

  task automatic step(input bit rst, input bit v, input logic [4:0] a, input logic [31:0] d, input bit cr);
    bit ready, acc;
    reset = rst;
    wr_valid = v;
    wr_addr = a;
    wr_data = d;
    clear_req = cr;
    #1;
    ready = (busy_left == 0) && !cr;
    check("wr_ready_pre", 32'(wr_ready), 32'(ready));
    acc = v && ready;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (pv) m[pa] = pd;
      if (busy_left == 0 && cr) busy_left = 32;
      else if (busy_left > 0) begin
        if (busy_left > 1) m[32 - busy_left] = '0;
        busy_left--;
      end
      pv = acc && (a != 5'd31);
      if (pv) begin
        pa = a;
        pd = d;
      end
    end
    #1;
    check("busy", 32'(busy), 32'(busy_left != 0));
    check("clear_done", 32'(clear_done), 32'(busy_left == 1));
    check("pend_valid", 32'(pend_valid), 32'(pv));
    if (pv) begin
      check("pend_addr", 32'(pend_addr), 32'(pa));
      check("pend_data", pend_data, pd);
    end
    for (int k = 0; k < 32; k++) check($sformatf("reg%0d", k), regs_out[k*32 +: 32], m[k]);
    if (busy) busy_cnt++;
    if (clear_done) done_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 32'd0, 0);
  endtask

  initial begin
    model_reset();
    step(1, 0, 5'd0, 32'd0, 0);
    step(1, 0, 5'd0, 32'd0, 0);
    check("rst_pend_addr", 32'(pend_addr), 32'd0);
    check("rst_pend_data", pend_data, 32'd0);
    step(0, 1, 5'd5, 32'hDEADBEEF, 0);
    check("dir_pend_addr5", 32'(pend_addr), 32'd5);
    idle(1);
    check("dir_reg5", regs_out[5*32 +: 32], 32'hDEADBEEF);
    step(0, 1, 5'd3, 32'h11, 0);
    step(0, 1, 5'd4, 32'h22, 0);
    step(0, 1, 5'd3, 32'h33, 0);
    idle(1);
    check("dir_reg3", regs_out[3*32 +: 32], 32'h33);
    check("dir_reg4", regs_out[4*32 +: 32], 32'h22);
    step(0, 1, 5'd31, 32'hFFFFFFFF, 0);
    idle(3);
    check("dir_reg31", regs_out[31*32 +: 32], 32'd0);
    step(0, 1, 5'd0, 32'd1, 0);
    step(0, 1, 5'd30, 32'd2, 0);
    idle(1);
    busy_cnt = 0;
    done_cnt = 0;
    step(0, 1, 5'd7, 32'hAA, 1);
    for (int i = 0; i < 34; i++) step(0, 1, 5'd7, 32'hAA, i == 5);
    check("dir_busy_cycles", 32'(busy_cnt), 32'd32);
    check("dir_done_pulses", 32'(done_cnt), 32'd1);
    check("dir_reg0_cleared", regs_out[0 +: 32], 32'd0);
    idle(1);
    check("dir_reg7_after", regs_out[7*32 +: 32], 32'hAA);
    step(0, 1, 5'd9, 32'h99, 0);
    done_cnt = 0;
    step(0, 0, 5'd0, 32'd0, 1);
    idle(9);
    step(1, 0, 5'd0, 32'd0, 0);
    check("dir_rst_busy", 32'(busy), 32'd0);
    idle(40);
    check("dir_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0,
           ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31)),
           $urandom, $urandom_range(0, 39) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
